mcu_core_param: RTL and testbench

Parametrised multi-cycle accumulator microcontroller core. It is the successor to the team's fixed 8-bit/10-word controller. Width and memory depths are generic, and the program is loaded through a valid/ready stream instead of a simulation-time file. It adds conditional jumps, a CALL/RET hardware stack, a HALT state and an error flag, and serves as the small sequencer core inside larger SoC blocks.

---
 rtl/mcu_pkg.sv | 32 +++
 rtl/mcu_alu.sv | 52 +++++
 rtl/mcu_core_param.sv | 171 +++++++++++++++++
 tb/tb_mcu_core_param.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the parametrised accumulator core.
// Contents: opcode encodings, the core state enum and the status-register bit
// positions (SR = {Z,C,S,O}, MSB to LSB).
package mcu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_t;

  localparam int F_Z = 3;
  localparam int F_C = 2;
  localparam int F_S = 1;
  localparam int F_O = 0;

endpackage

// File: rtl/mcu_alu.sv
// Combinational ALU for the accumulator core.
// Ports: acc (accumulator), operand (DR or immediate), opcode (IR opcode
// field) in; result and flags {Z,C,S,O} out. Non-ALU opcodes pass acc through.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  input  logic [3:0]    opcode,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);

  logic [DW:0] sum;
  logic [DW:0] diff;
  logic        c;
  logic        o;

  assign sum  = {1'b0, acc} + {1'b0, operand};
  // Top bit of the widened difference is the borrow (acc < operand unsigned).
  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result = acc;
    c      = 1'b0;
    o      = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDI: begin
        result = sum[DW-1:0];
        c      = sum[DW];
        o      = (acc[DW-1] == operand[DW-1]) && (sum[DW-1] != acc[DW-1]);
      end
      OP_SUB: begin
        result = diff[DW-1:0];
        c      = diff[DW];
        o      = (acc[DW-1] != operand[DW-1]) && (diff[DW-1] != acc[DW-1]);
      end
      OP_AND:  result = acc & operand;
      OP_OR:   result = acc | operand;
      OP_XOR:  result = acc ^ operand;
      default: ;
    endcase
    flags      = 4'b0000;
    flags[F_Z] = (result == '0);
    flags[F_C] = c;
    flags[F_S] = result[DW-1];
    flags[F_O] = o;
  end

endmodule

// File: rtl/mcu_core_param.sv
// Parametrised multi-cycle accumulator core with streamed program load.
// Ports: clk, rst (sync, active-high); ld_valid/ld_ready/ld_data/ld_last
// program load stream; halted, err (sticky stack fault), pc_o, acc_o,
// sr_o {Z,C,S,O}. Each instruction runs FETCH -> DECODE -> EXECUTE.
module mcu_core_param
  import mcu_pkg::*;
#(
  parameter int DW     = 8,
  parameter int PDEPTH = 16,
  parameter int DDEPTH = 16,
  parameter int SDEPTH = 4,
  localparam int IW    = DW + 4,
  localparam int PW    = $clog2(PDEPTH),
  localparam int AW    = $clog2(DDEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          halted,
  output logic          err,
  output logic [PW-1:0] pc_o,
  output logic [DW-1:0] acc_o,
  output logic [3:0]    sr_o
);

  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int SIW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   load_addr, pc, pc_inc, pc_nxt, target;
  logic [DW-1:0]   acc, dr, k, alu_opnd, alu_res;
  logic [3:0]      sr, alu_flags, op;
  logic [IW-1:0]   ir;
  logic [SPW-1:0]  sp;
  logic            err_q;
  logic            ld_beat, ld_done, stk_full, stk_empty, push, st_en;

  logic [IW-1:0]   pmem  [PDEPTH];
  logic [DW-1:0]   dmem  [DDEPTH];
  logic [PW-1:0]   stack [SDEPTH];

  assign op        = ir[IW-1:DW];
  assign k         = ir[DW-1:0];
  assign target    = k[PW-1:0];
  assign pc_inc    = pc + PW'(1);
  assign stk_full  = (sp == SPW'(SDEPTH));
  assign stk_empty = (sp == '0);

  assign ld_ready  = (state == S_LOAD) && !rst;
  assign ld_beat   = ld_valid && ld_ready;
  // Either terminator ends the load; both on the same beat is still one exit.
  assign ld_done   = ld_beat && (ld_last || (load_addr == PW'(PDEPTH - 1)));

  assign push      = !rst && (state == S_EXEC) && (op == OP_CALL) && !stk_full;
  assign st_en     = !rst && (state == S_EXEC) && (op == OP_ST);

  assign alu_opnd  = (op == OP_ADDI) ? k : dr;

  mcu_alu #(.DW(DW)) u_alu (
    .acc     (acc),
    .operand (alu_opnd),
    .opcode  (op),
    .result  (alu_res),
    .flags   (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (ld_done) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        if ((op == OP_HALT) || (op == OP_CALL && stk_full) ||
            (op == OP_RET && stk_empty))
          state_nxt = S_HALT;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // Branches test SR as it stood entering EXECUTE; a faulting CALL/RET keeps
  // PC on the offending instruction.
  always_comb begin
    pc_nxt = pc_inc;
    case (op)
      OP_JMP:  pc_nxt = target;
      OP_JZ:   if (sr[F_Z]) pc_nxt = target;
      OP_JC:   if (sr[F_C]) pc_nxt = target;
      OP_CALL: pc_nxt = stk_full ? pc : target;
      OP_RET:  pc_nxt = stk_empty ? pc : stack[SIW'(sp - SPW'(1))];
      OP_HALT: pc_nxt = pc;
      default: ;
    endcase
  end

  // Memories and stack storage carry no reset; PMem survives rst.
  always_ff @(posedge clk) begin
    if (ld_beat) pmem[load_addr] <= ld_data;
    if (st_en)   dmem[ir[AW-1:0]] <= acc;
    if (push)    stack[SIW'(sp)] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_addr <= '0;
      pc        <= '0;
      acc       <= '0;
      sr        <= '0;
      sp        <= '0;
      err_q     <= 1'b0;
      ir        <= '0;
      dr        <= '0;
    end else begin
      case (state)
        S_LOAD: if (ld_beat) begin
          load_addr <= load_addr + PW'(1);
          if (ld_done) begin
            load_addr <= '0;
            pc        <= '0;
            acc       <= '0;
            sr        <= '0;
            sp        <= '0;
            ir        <= '0;
            dr        <= '0;
          end
        end
        S_FETCH:  ir <= pmem[pc];
        S_DECODE: dr <= dmem[ir[AW-1:0]];
        S_EXEC: begin
          pc <= pc_nxt;
          case (op)
            OP_LDI: acc <= k;
            OP_LD:  acc <= dr;
            OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              acc <= alu_res;
              sr  <= alu_flags;
            end
            OP_CALL: begin
              if (stk_full) err_q <= 1'b1;
              else          sp    <= sp + SPW'(1);
            end
            OP_RET: begin
              if (stk_empty) err_q <= 1'b1;
              else           sp    <= sp - SPW'(1);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == S_HALT);
  assign err    = err_q;
  assign pc_o   = pc;
  assign acc_o  = acc;
  assign sr_o   = sr;

endmodule

// File: tb/tb_mcu_core_param.sv
// Bench for mcu_core_param: directed programs plus random programs checked
// instruction-by-instruction against an instruction-level reference model,
// and a wide (DW=16, PDEPTH=64) instance exercising the full-depth auto exit.
module tb_mcu_core_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld_valid = 1'b0, ld_last = 1'b0, ld_ready, halted, err;
  logic [11:0] ld_data = '0;
  logic [3:0]  pc, sr;
  logic [7:0]  acc;

  mcu_core_param #(.DW(8), .PDEPTH(16), .DDEPTH(16), .SDEPTH(4)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .halted(halted), .err(err),
    .pc_o(pc), .acc_o(acc), .sr_o(sr)
  );

  logic        b_valid = 1'b0, b_last = 1'b0, b_ready, b_halted, b_err;
  logic [19:0] b_data = '0;
  logic [5:0]  b_pc;
  logic [15:0] b_acc;
  logic [3:0]  b_sr;

  mcu_core_param #(.DW(16), .PDEPTH(64), .DDEPTH(16), .SDEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .ld_valid(b_valid), .ld_ready(b_ready),
    .ld_data(b_data), .ld_last(b_last), .halted(b_halted), .err(b_err),
    .pc_o(b_pc), .acc_o(b_acc), .sr_o(b_sr)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (one call = one instruction) ----------
  logic [11:0] prog [16];
  int m_pc, m_acc, m_sr, m_err, m_halt;
  int m_dm [16];
  int m_stk [$];

  function automatic logic [11:0] ins(input int op, input int k);
    logic [11:0] w;
    w = {op[3:0], k[7:0]};
    return w;
  endfunction

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic m_reset();
    m_pc = 0; m_acc = 0; m_sr = 0; m_err = 0; m_halt = 0;
    m_stk.delete();
  endtask

  task automatic m_step();
    int op, k, a, npc, opnd, r, c, o, s;
    op = int'(prog[m_pc][11:8]);
    k  = int'(prog[m_pc][7:0]);
    a  = k % 16;
    npc = (m_pc + 1) % 16;
    case (op)
      1: m_acc = k;
      2: m_acc = m_dm[a];
      3: m_dm[a] = m_acc;
      4, 5, 6, 7, 8, 9: begin
        opnd = (op == 5) ? k : m_dm[a];
        c = 0; o = 0; r = 0;
        case (op)
          4, 5: begin
            r = m_acc + opnd;
            c = (r > 255) ? 1 : 0;
            s = sgn(m_acc) + sgn(opnd);
            o = (s > 127 || s < -128) ? 1 : 0;
            r = r % 256;
          end
          6: begin
            c = (m_acc < opnd) ? 1 : 0;
            s = sgn(m_acc) - sgn(opnd);
            o = (s > 127 || s < -128) ? 1 : 0;
            r = (m_acc - opnd + 256) % 256;
          end
          7: r = m_acc & opnd;
          8: r = m_acc | opnd;
          default: r = m_acc ^ opnd;
        endcase
        m_acc = r;
        m_sr = 0;
        if (r == 0)   m_sr += 8;
        if (c != 0)   m_sr += 4;
        if (r >= 128) m_sr += 2;
        if (o != 0)   m_sr += 1;
      end
      10: npc = a;
      11: if ((m_sr & 8) != 0) npc = a;
      12: if ((m_sr & 4) != 0) npc = a;
      13: if (m_stk.size() == 4) begin m_err = 1; m_halt = 1; npc = m_pc; end
          else begin m_stk.push_back(npc); npc = a; end
      14: if (m_stk.size() == 0) begin m_err = 1; m_halt = 1; npc = m_pc; end
          else npc = m_stk.pop_back();
      15: begin m_halt = 1; npc = m_pc; end
      default: ;
    endcase
    m_pc = npc;
  endtask

  function automatic logic [31:0] expv();
    logic [31:0] v;
    v = '0;
    v[17] = m_halt[0]; v[16] = m_err[0];
    v[15:12] = m_sr[3:0]; v[11:8] = m_pc[3:0]; v[7:0] = m_acc[7:0];
    return v;
  endfunction

  function automatic logic [31:0] obsv();
    return {14'b0, halted, err, sr, pc, acc};
  endfunction

  // ---------------- drivers ------------------------------------------------
  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = ins(0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0;
    @(posedge clk); #1;
    chk("rdy_in_rst", ld_ready, 0);
    rst = 1'b0; #1;
    chk("rdy_after_rst", ld_ready, 1);
    chk("rst_state", obsv(), 0);
    m_reset();
  endtask

  task automatic load(input int n, input bit last, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) begin ld_valid = 1'b0; @(posedge clk); #1; end
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = last && (i == n - 1);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("load_exit", ld_ready, 0);
  endtask

  task automatic run(input int max_ins);
    for (int i = 0; i < max_ins && m_halt == 0; i++) begin
      m_step();
      repeat (3) @(posedge clk); #1;
      chk($sformatf("step pc=%0d", m_pc), obsv(), expv());
    end
    if (m_halt != 0) begin
      repeat (4) @(posedge clk); #1;
      chk("frozen", obsv(), expv());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int op, k;
    do_reset();

    // Wide instance: 64 beats, no ld_last, must leave LOAD on its own.
    for (int i = 0; i < 64; i++) begin
      if (i == 0)       b_data = {4'h1, 16'hABCD};
      else if (i == 1)  b_data = {4'h5, 16'h5433};
      else if (i == 63) b_data = {4'hF, 16'h0000};
      else              b_data = {4'h0, 16'h0000};
      b_valid = 1'b1;
      @(posedge clk); #1;
      if (i == 62) chk("w_ready_63", b_ready, 1);
    end
    b_valid = 1'b0;
    chk("w_auto_exit", b_ready, 0);
    for (int c = 0; c < 300 && !b_halted; c++) begin @(posedge clk); #1; end
    chk("w_halted", b_halted, 1);
    chk("w_acc", b_acc, 16'h0000);
    chk("w_sr", b_sr, 4'b1100);
    chk("w_pc", b_pc, 63);
    chk("w_err", b_err, 0);

    // LDI 5; ADDI 3; HALT with ld_valid toggling.
    clr_prog();
    prog[0] = ins(1, 5); prog[1] = ins(5, 3); prog[2] = ins(15, 0);
    do_reset(); load(3, 1'b1, 1'b1);
    repeat (8) @(posedge clk); #1;
    chk("halt_t8", halted, 0);
    @(posedge clk); #1;
    chk("halt_t9", halted, 1);
    chk("t1_acc", acc, 8);
    chk("t1_sr", sr, 4'b0000);

    // Carry/zero then signed overflow.
    clr_prog();
    prog[0] = ins(1, 'hFF); prog[1] = ins(5, 1);
    prog[2] = ins(1, 'h7F); prog[3] = ins(5, 1); prog[4] = ins(15, 0);
    do_reset(); load(5, 1'b1, 1'b0);
    run(2);
    chk("ff+1_acc", acc, 0);
    chk("ff+1_sr", sr, 4'b1100);
    run(2);
    chk("7f+1_acc", acc, 8'h80);
    chk("7f+1_sr", sr, 4'b0011);
    run(5);

    // ST/LD forwarding, SUB to zero, JZ.
    clr_prog();
    prog[0] = ins(1, 'h10); prog[1] = ins(3, 3); prog[2] = ins(1, 0);
    prog[3] = ins(2, 3);    prog[4] = ins(6, 3); prog[5] = ins(11, 7);
    prog[7] = ins(15, 0);
    do_reset(); load(8, 1'b1, 1'b0);
    run(5);
    chk("sub_acc", acc, 0);
    chk("sub_z", sr[3], 1);
    run(1);
    chk("jz_pc", pc, 7);
    run(5);

    // Stack overflow on the fifth nested CALL.
    clr_prog();
    prog[0] = ins(13, 8); prog[8] = ins(13, 8);
    do_reset(); load(9, 1'b1, 1'b0);
    run(4);
    chk("call4_err", err, 0);
    run(1);
    chk("ovf_err", err, 1);
    chk("ovf_halt", halted, 1);
    chk("ovf_pc", pc, 8);

    // CALL/RET pair, then a bare RET.
    clr_prog();
    prog[0] = ins(1, 1); prog[1] = ins(13, 5); prog[2] = ins(5, 2);
    prog[3] = ins(15, 0); prog[5] = ins(5, 4); prog[6] = ins(14, 0);
    do_reset(); load(7, 1'b1, 1'b0);
    run(4);
    chk("ret_pc", pc, 2);
    run(5);
    chk("callret_acc", acc, 7);
    clr_prog();
    prog[0] = ins(14, 0);
    do_reset(); load(1, 1'b1, 1'b0);
    run(1);
    chk("unf_err", err, 1);
    chk("unf_halt", halted, 1);

    // Reset while in EXECUTE.
    clr_prog();
    prog[0] = ins(1, 'h55); prog[1] = ins(5, 1); prog[2] = ins(10, 0);
    do_reset(); load(3, 1'b1, 1'b0);
    run(2);
    repeat (2) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("xrst_ready", ld_ready, 1);
    chk("xrst_acc", acc, 0);
    chk("xrst_pc", pc, 0);
    chk("xrst_err", err, 0);

    // Random programs; reads restricted to DMem words 0/1, set up first.
    for (int p = 0; p < 40; p++) begin
      prog[0] = ins(1, int'($urandom_range(0, 255))); prog[1] = ins(3, 0);
      prog[2] = ins(1, int'($urandom_range(0, 255))); prog[3] = ins(3, 1);
      for (int i = 4; i < 16; i++) begin
        op = int'($urandom_range(0, 15));
        k  = int'($urandom_range(0, 255));
        if (op == 2 || (op >= 4 && op <= 9 && op != 5)) k = k & 'hF1;
        if (op == 15 && $urandom_range(0, 2) != 0) op = 0;
        prog[i] = ins(op, k);
      end
      do_reset();
      load(16, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run(30);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
